boa_mem_serial_resp: RTL and testbench

Responder (MEM side) of the standard Boa memory bus that serves each word-wide access by issuing byte-wide transfers on an external 8-bit memory port with a strobe/acknowledge handshake. Sits at a leaf of the memory mux or crossbar tree, in front of slow or narrow devices such as parallel flash, external SRAM or a byte-wide peripheral. It stalls the bus through `ready` until every required byte beat has completed.

---
 rtl/boa_pkg.sv | 23 ++
 rtl/boa_mem_bus.sv | 25 ++
 rtl/boa_lane_sel.sv | 28 ++
 rtl/boa_mem_serial_resp.sv | 151 +++++++++++++++
 tb/tb_boa_mem_serial_resp.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boa_pkg.sv
// ============================================================================
// Module : boa_pkg
// Brief  : Shared types and helpers for the Boa memory-bus responders.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } boa_mem_serial_state_t;

    // Width of a byte-lane index for a data bus of the given size.
    function automatic int boa_lane_w(input int dlen);
        return $clog2(dlen / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/boa_mem_bus.sv
// ============================================================================
// Module : boa_mem_bus
// Brief  : Boa memory bus bundle; CPU side initiates, MEM side responds.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface boa_mem_bus #(
    parameter int alen = 32,
    parameter int dlen = 32
);
    localparam int wes = dlen / 8;

    logic            re;
    logic [wes-1:0]  we;
    logic [alen-1:2] addr;
    logic [dlen-1:0] wdata;
    logic            ready;
    logic [dlen-1:0] rdata;

    modport MEM (input re, we, addr, wdata, output ready, rdata);
    modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

`default_nettype wire

// File: rtl/boa_lane_sel.sv
// ============================================================================
// Module : boa_lane_sel
// Brief  : Lowest-set-lane priority encoder with a last-beat flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boa_lane_sel #(
    parameter int WES = 4,
    parameter int LW  = 2
) (
    input  logic [WES-1:0] mask_i,
    output logic [LW-1:0]  lane_o,
    output logic           last_o
);
    logic [WES-1:0] rest;

    always_comb begin
        lane_o = '0;
        for (int i = WES - 1; i >= 0; i--) begin
            if (mask_i[i]) lane_o = LW'(i);
        end
        rest   = mask_i & ~(WES'(1) << lane_o);
        last_o = (rest == '0);
    end
endmodule

`default_nettype wire

// File: rtl/boa_mem_serial_resp.sv
// ============================================================================
// Module : boa_mem_serial_resp
// Brief  : Boa bus responder serialising word accesses into byte beats on an
//          8-bit strobe/ack port. BOA_MEM_SERIAL_POSTED_EN enables posted writes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boa_mem_serial_resp
    import boa_pkg::*;
#(
    parameter int alen = 32,
    parameter int dlen = 32
) (
    input  logic            clk,
    input  logic            rst,
    boa_mem_bus.MEM         bus,
    output logic            ext_re,
    output logic            ext_we,
    output logic [alen-1:0] ext_addr,
    output logic [7:0]      ext_wdata,
    input  logic            ext_ack,
    input  logic [7:0]      ext_rdata
);
    localparam int wes = dlen / 8;
    localparam int LW  = boa_lane_w(dlen);
`ifdef BOA_MEM_SERIAL_POSTED_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    boa_mem_serial_state_t state_q, state_d;
    logic [alen-1:2] addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic [dlen-1:0] wdata_q, wdata_d, pend_wdata_q, pend_wdata_d;
    logic [dlen-1:0] rdata_q, rdata_d;
    logic [wes-1:0]  mask_q, mask_d, pend_mask_q, pend_mask_d;
    logic            write_q, write_d, pend_write_q, pend_write_d;
    logic            posted_q, posted_d, pend_q, pend_d;

    logic [LW-1:0]   lane;
    logic            last;
    logic            req, req_write, ready, accept;
    logic [wes-1:0]  req_mask;

    boa_lane_sel #(.WES(wes), .LW(LW)) u_lane_sel (
        .mask_i (mask_q),
        .lane_o (lane),
        .last_o (last)
    );

    assign req_write = |bus.we;
    assign req       = bus.re | req_write;
    assign req_mask  = req_write ? bus.we : '1;
    // A posted write keeps the bus open until a second request has to wait.
    assign ready     = (state_q != ST_XFER) | (posted_q & ~pend_q);
    assign accept    = ready & req;

    assign bus.ready = ready;
    assign bus.rdata = rdata_q;
    assign ext_re    = (state_q == ST_XFER) & ~write_q;
    assign ext_we    = (state_q == ST_XFER) & write_q;
    assign ext_addr  = {addr_q, 2'b00} | alen'(lane);
    assign ext_wdata = wdata_q[8*int'(lane) +: 8];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        write_d      = write_q;
        posted_d     = posted_q;
        rdata_d      = rdata_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_mask_d  = pend_mask_q;
        pend_write_d = pend_write_q;

        if (state_q == ST_XFER) begin
            if (ext_ack) begin
                mask_d = mask_q & ~(wes'(1) << lane);
                if (!write_q) rdata_d[8*int'(lane) +: 8] = ext_rdata;
                if (last) begin
                    posted_d = 1'b0;
                    if (pend_q) begin
                        // The waiting request runs fully stalled, not posted.
                        pend_d  = 1'b0;
                        addr_d  = pend_addr_q;
                        wdata_d = pend_wdata_q;
                        mask_d  = pend_mask_q;
                        write_d = pend_write_q;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
        end else begin
            state_d = ST_IDLE;
        end

        if (accept) begin
            if (state_q != ST_XFER || (ext_ack && last)) begin
                state_d  = ST_XFER;
                addr_d   = bus.addr;
                wdata_d  = bus.wdata;
                mask_d   = req_mask;
                write_d  = req_write;
                posted_d = POSTED & req_write;
            end else begin
                pend_d       = 1'b1;
                pend_addr_d  = bus.addr;
                pend_wdata_d = bus.wdata;
                pend_mask_d  = req_mask;
                pend_write_d = req_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            write_q      <= 1'b0;
            posted_q     <= 1'b0;
            rdata_q      <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_mask_q  <= '0;
            pend_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            write_q      <= write_d;
            posted_q     <= posted_d;
            rdata_q      <= rdata_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_mask_q  <= pend_mask_d;
            pend_write_q <= pend_write_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_boa_mem_serial_resp.sv
// ============================================================================
// Module : tb_boa_mem_serial_resp
// Brief  : Scoreboard bench for boa_mem_serial_resp with a byte-wide device.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boa_mem_serial_resp;
    import boa_pkg::*;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [7:0]  d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_re, ext_we, ext_ack;
    logic [31:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          waits   = 0;
    logic [3:0]  wcnt;
    logic        dev_init;
    logic        rst_edge;
    logic        hold_v;
    logic [1:0]  hold_s;
    logic [31:0] hold_a;

    logic [7:0]  dev_mem [0:4095];
    logic [7:0]  ref_mem [0:4095];
    beat_t       exp_q[$];
    logic [31:0] exp_rd[$];

    boa_mem_bus #(.alen(32), .dlen(32)) bus_if ();

    boa_mem_serial_resp #(.alen(32), .dlen(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .ext_re    (ext_re),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        if (i >= 256 && i < 260) return 8'((i - 255) * 17);
        return 8'(i * 13 + 5);
    endfunction

    // Device: acks after `waits` cycles of strobe, reads/writes a byte array.
    assign ext_ack   = (ext_re | ext_we) & (int'(wcnt) >= waits);
    assign ext_rdata = dev_mem[ext_addr[11:0]];

    always @(posedge clk) begin
        if (rst || !(ext_re || ext_we) || ext_ack) wcnt <= '0;
        else wcnt <= wcnt + 4'd1;
        rst_edge <= rst;
        if (dev_init) begin
            for (int i = 0; i < 4096; i++) dev_mem[i] <= pat(i);
        end else if (ext_we && ext_ack && !rst) begin
            dev_mem[ext_addr[11:0]] <= ext_wdata;
        end
    end

    always @(negedge clk) begin
        if (hold_v && !rst_edge) begin
            chk("hold_strobe", 64'({ext_re, ext_we}), 64'(hold_s));
            chk("hold_addr", 64'(ext_addr), 64'(hold_a));
        end
        if ((ext_re || ext_we) && ext_ack && !rst) begin
            if (exp_q.size() == 0) begin
                chk("beat_extra", 64'(ext_addr), 64'hFFFF_FFFF);
            end else begin
                chk("beat_we", 64'(ext_we), 64'(exp_q[0].w));
                chk("beat_addr", 64'(ext_addr), 64'(exp_q[0].a));
                if (exp_q[0].w) chk("beat_wdata", 64'(ext_wdata), 64'(exp_q[0].d));
                void'(exp_q.pop_front());
            end
        end
        hold_v <= (ext_re | ext_we) & ~ext_ack;
        hold_s <= {ext_re, ext_we};
        hold_a <= ext_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.re    = 1'b0;
        bus_if.we    = 4'b0000;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
    endtask

    // Present a request and record the beats and read data it must produce.
    task automatic issue(input logic rd, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] wd);
        logic        is_w;
        logic [3:0]  m;
        logic [31:0] rv;
        is_w = (we != 4'b0000);
        m    = is_w ? we : 4'b1111;
        bus_if.re    = rd;
        bus_if.we    = we;
        bus_if.addr  = a[31:2];
        bus_if.wdata = wd;
        rv = '0;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                exp_q.push_back('{w: is_w, a: {a[31:2], 2'(l)}, d: wd[8*l +: 8]});
                if (is_w) ref_mem[{a[11:2], 2'(l)}] = wd[8*l +: 8];
            end
            rv[8*l +: 8] = ref_mem[{a[11:2], 2'(l)}];
        end
        if (!is_w) exp_rd.push_back(rv);
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!bus_if.ready && n < 200) begin
            n++;
            step();
        end
        if (!bus_if.ready) chk({tag, "_timeout"}, 64'(bus_if.ready), 64'd1);
    endtask

    task automatic chk_rdata(input string tag);
        if (exp_rd.size() == 0) begin
            chk({tag, "_no_exp"}, 64'(bus_if.rdata), 64'hDEAD_BEEF);
        end else begin
            chk(tag, 64'(bus_if.rdata), 64'(exp_rd.pop_front()));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        dev_init = 1'b1;
        idle_bus();
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        repeat (3) step();
        dev_init = 1'b0;
        chk("rst_ready", 64'(bus_if.ready), 64'd1);
        chk("rst_strobes", 64'({ext_re, ext_we}), 64'd0);
        chk("rst_ext_addr", 64'(ext_addr), 64'd0);
        chk("rst_ext_wdata", 64'(ext_wdata), 64'd0);
        chk("rst_rdata", 64'(bus_if.rdata), 64'd0);
        rst = 1'b0;
        step();

        // Zero-wait read: one beat per cycle in cycles 1..4, DONE in cycle 5.
        issue(1'b1, 4'b0000, 32'h100, 32'h0);
        step();
        idle_bus();
        for (int c = 0; c < 4; c++) begin
            chk("rd_ready_low", 64'(bus_if.ready), 64'd0);
            chk("rd_ext_re", 64'(ext_re), 64'd1);
            chk("rd_ext_addr", 64'(ext_addr), 64'(32'h100 + c));
            step();
        end
        chk("rd_ready_c5", 64'(bus_if.ready), 64'd1);
        chk_rdata("rd_rdata");
        step();

        // Masked write: lanes 0 and 2 only.
        issue(1'b0, 4'b0101, 32'h20, 32'hAABB_CCDD);
        step();
        idle_bus();
        wait_ready("wr", n);
        chk("wr_ready_low_cycles", 64'(n), 64'd2);
        chk("wr_keeps_rdata", 64'(bus_if.rdata), 64'h4433_2211);
        step();

        // Three wait cycles per beat.
        waits = 3;
        issue(1'b1, 4'b0000, 32'h200, 32'h0);
        step();
        idle_bus();
        wait_ready("rdw", n);
        chk("rdw_ready_low_cycles", 64'(n), 64'd16);
        chk_rdata("rdw_rdata");
        waits = 0;
        step();

        // Back-to-back: read, then write presented in the DONE cycle.
        issue(1'b1, 4'b0000, 32'h300, 32'h0);
        step();
        idle_bus();
        wait_ready("b2b_rd", n);
        chk("b2b_rd_cycles", 64'(n), 64'd4);
        chk_rdata("b2b_rdata");
        issue(1'b0, 4'b1111, 32'h40, 32'h0102_0304);
        step();
        idle_bus();
        chk("b2b_wr_strobe", 64'(ext_we), 64'd1);
        chk("b2b_wr_addr", 64'(ext_addr), 64'h40);
        chk("b2b_state", 64'(dut.state_q), 64'(ST_XFER));
        wait_ready("b2b_wr", n);
        chk("b2b_wr_cycles", 64'(n), 64'd4);
        step();

        // Reset in the middle of a stalled read beat.
        waits = 3;
        issue(1'b1, 4'b0000, 32'h104, 32'h0);
        step();
        idle_bus();
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_strobes", 64'({ext_re, ext_we}), 64'd0);
        chk("mid_rst_ready", 64'(bus_if.ready), 64'd1);
        chk("mid_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("mid_rst_rdata", 64'(bus_if.rdata), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_rd.delete();
        waits = 0;
        step();

`ifdef BOA_MEM_SERIAL_POSTED_EN
        // Posted write followed at once by a read of the same word.
        issue(1'b0, 4'b1111, 32'h50, 32'h1234_5678);
        step();
        chk("post_wr_ready", 64'(bus_if.ready), 64'd1);
        issue(1'b1, 4'b0000, 32'h50, 32'h0);
        step();
        idle_bus();
        chk("post_rd_stall", 64'(bus_if.ready), 64'd0);
        wait_ready("post_rd", n);
        chk("post_rd_cycles", 64'(n), 64'd7);
        chk_rdata("post_rd_rdata");
`else
        // Write stalls like a read, then the read sees the written word.
        issue(1'b0, 4'b1111, 32'h50, 32'h1234_5678);
        step();
        idle_bus();
        chk("wr_stall", 64'(bus_if.ready), 64'd0);
        wait_ready("wr_full", n);
        chk("wr_full_cycles", 64'(n), 64'd4);
        issue(1'b1, 4'b0000, 32'h50, 32'h0);
        step();
        idle_bus();
        wait_ready("rd_back", n);
        chk("rd_back_cycles", 64'(n), 64'd4);
        chk_rdata("rd_back_rdata");
`endif
        step();
        step();
        chk("sb_beats_empty", 64'(exp_q.size()), 64'd0);
        chk("sb_rdata_empty", 64'(exp_rd.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
